mcbsp_dsp_tx: RTL
=================

MCBSP_DSP_TX -- requirements
Module: mcbsp_dsp_tx

Interface
REQ-001 Parameter CLK_DIV, default 5: clk_50m cycles per half-period of mcbsp_clkx (5 -> 5 MHz bit clock); legal range 2..255.
REQ-002 Parameter WORDS_PER_REQ, default 6500: 32-bit words sent per accepted read_quest; legal range 1..65535.
REQ-003 Parameter RD_WAIT, default 8: clk_50m cycles from FETCH entry to capture of data_dsp; covers upstream update synchroniser plus RAM read latency.
REQ-004 clk_50m  in  1  system clock; all logic is in this domain.
REQ-005 cfg_rst  in  1  reset; asynchronous, active-high.
REQ-006 read_quest  in  1  one-cycle pulse from the capture buffer: a half-buffer is ready to drain.
REQ-007 data_dsp  in  32  buffer read data; {Q[15:0], I[15:0]}.
REQ-008 tx_enable  in  1  level; 1 permits new bursts.
REQ-009 data_updated  out  1  advance strobe to the buffer read-address logic.
REQ-010 mcbsp_clkx  out  1  McBSP transmit clock, free-running.
REQ-011 mcbsp_fsx  out  1  McBSP frame sync, active-high.
REQ-012 mcbsp_dx  out  1  McBSP serial data, MSB first.
REQ-013 busy  out  1  1 whenever the FSM is not in IDLE.
REQ-014 word_cnt  out  16  words completed in the current burst.
REQ-015 overrun  out  1  one-cycle pulse: read_quest dropped.

Function
REQ-016 Divider SHALL toggle mcbsp_clkx every CLK_DIV cycles; bit_tick SHALL be the single clk_50m cycle in which mcbsp_clkx goes 0->1; bit period = 2*CLK_DIV cycles.
REQ-017 FSM states SHALL be IDLE, FETCH, SHIFT, ADV.
REQ-018 IDLE: read_quest=1 and tx_enable=1 -> FETCH next cycle; word_cnt cleared to 0 on the same edge.
REQ-019 FETCH: wait counter runs RD_WAIT cycles; in the last cycle, data_dsp is loaded into a 32-bit shift register; then -> SHIFT.
REQ-020 SHIFT: on each bit_tick, the shift register SHALL shift left by one and mcbsp_dx SHALL take the outgoing MSB. mcbsp_dx and mcbsp_fsx SHALL change only on bit_tick cycles.
REQ-021 mcbsp_fsx SHALL be 1 for exactly one bit period, coincident with bit 31 (zero data delay).
REQ-022 On the 33rd bit_tick after SHIFT entry, mcbsp_dx and mcbsp_fsx SHALL go 0, word_cnt SHALL increment by 1, and the FSM SHALL go -> ADV.
REQ-023 ADV: data_updated SHALL be 1 for 4 cycles, then 0 for 4 cycles.
REQ-024 End of ADV: next state is IDLE if word_cnt==WORDS_PER_REQ or tx_enable==0; otherwise FETCH.
REQ-025 Dropping tx_enable mid-burst SHALL complete the current word including ADV, then return to IDLE; word_cnt SHALL hold its value.
REQ-026 read_quest=1 in any state other than IDLE, or in IDLE with tx_enable=0, SHALL assert overrun for that cycle and SHALL NOT change state.
REQ-027 word_cnt SHALL be 16-bit unsigned and SHALL hold its value in IDLE until the next accepted request.
REQ-028 Outside SHIFT, mcbsp_dx and mcbsp_fsx SHALL be 0. Outside ADV, data_updated SHALL be 0.

Reset
REQ-029 While cfg_rst=1: FSM=IDLE; divider, wait counter, shift register and word_cnt all 0; all outputs 0, including mcbsp_clkx.
REQ-030 Reset asserted mid-burst SHALL abort immediately with no completion of the current word; after release, the block SHALL wait for a new read_quest.

Verification
REQ-031 Single word: CLK_DIV=2, WORDS_PER_REQ=1, data_dsp=32'hA5C3_0F81, pulse read_quest -> after 8 cycles, 32 bits 1010_0101... on dx; fsx high one 4-cycle bit period with bit 31; 4-cycle data_updated pulse; word_cnt=1; busy=0.
REQ-032 Burst: WORDS_PER_REQ=3; data_dsp increments on each data_updated -> three frames carrying successive values; three data_updated pulses; word_cnt=3; return to IDLE.
REQ-033 Overrun: read_quest while busy=1 -> one-cycle overrun pulse; burst length unchanged.
REQ-034 Disable mid-burst: WORDS_PER_REQ=5; tx_enable=0 during the 2nd word -> 2nd word completes; IDLE with word_cnt=2; no 3rd frame.
REQ-035 Reset mid-SHIFT: cfg_rst pulsed at bit 10 -> all outputs 0 immediately; after release, idle until read_quest; next frame begins at bit 31 with fsx.
REQ-036 Gating: read_quest with tx_enable=0 -> overrun=1 for one cycle; busy stays 0; no clkx-aligned data activity on dx.

Source files
------------

// File: rtl/mcbsp_dsp_tx.sv
// rtl/mcbsp_dsp_tx.sv - McBSP transmitter draining 32-bit I/Q words from the capture buffer
module mcbsp_dsp_tx #(
  parameter int CLK_DIV       = 5,
  parameter int WORDS_PER_REQ = 6500,
  parameter int RD_WAIT       = 8
) (
  input  logic        clk_50m,
  input  logic        cfg_rst,
  input  logic        read_quest,
  input  logic [31:0] data_dsp,
  input  logic        tx_enable,
  output logic        data_updated,
  output logic        mcbsp_clkx,
  output logic        mcbsp_fsx,
  output logic        mcbsp_dx,
  output logic        busy,
  output logic [15:0] word_cnt,
  output logic        overrun
);

  localparam int              WAIT_W       = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(RD_WAIT - 1);
  localparam logic [7:0]      DIV_LAST     = 8'(CLK_DIV - 1);
  localparam logic [15:0]     WORDS_TARGET = 16'(WORDS_PER_REQ);
  localparam logic [5:0]      BIT_END      = 6'd32;
  localparam logic [2:0]      ADV_LAST     = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_ADV
  } state_t;

  // Bit-clock divider
  logic [7:0] div_cnt_q, div_cnt_d;
  logic       clkx_q, clkx_d;
  logic       div_end;
  logic       bit_tick;

  // Transmit FSM and datapath
  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]       shreg_q, shreg_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic [2:0]        adv_cnt_q, adv_cnt_d;
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic              dx_q, dx_d;
  logic              fsx_q, fsx_d;

  // Divider next state: toggle clkx every CLK_DIV cycles, tick on the rising toggle
  always_comb begin
    div_end   = (div_cnt_q == DIV_LAST);
    div_cnt_d = div_end ? 8'd0 : (div_cnt_q + 8'd1);
    clkx_d    = div_end ? ~clkx_q : clkx_q;
    bit_tick  = div_end & ~clkx_q;
  end

  // Divider registers; clkx free-runs whenever reset is released
  always_ff @(posedge clk_50m or posedge cfg_rst) begin
    if (cfg_rst) begin
      div_cnt_q <= 8'd0;
      clkx_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      clkx_q    <= clkx_d;
    end
  end

  // FSM next state plus shift/count datapath; dx and fsx only move on bit_tick
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    adv_cnt_d  = adv_cnt_q;
    word_cnt_d = word_cnt_q;
    dx_d       = dx_q;
    fsx_d      = fsx_q;

    case (state_q)
      ST_IDLE: begin
        if (read_quest && tx_enable) begin
          state_d    = ST_FETCH;
          word_cnt_d = 16'd0;
          wait_cnt_d = '0;
        end
      end

      ST_FETCH: begin
        // Read data is only trusted on the last wait cycle
        if (wait_cnt_q == WAIT_LAST) begin
          shreg_d   = data_dsp;
          bit_cnt_d = 6'd0;
          state_d   = ST_SHIFT;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      ST_SHIFT: begin
        if (bit_tick) begin
          if (bit_cnt_q == BIT_END) begin
            // Extra tick closes out the last bit period before releasing the line
            dx_d       = 1'b0;
            fsx_d      = 1'b0;
            word_cnt_d = word_cnt_q + 16'd1;
            adv_cnt_d  = 3'd0;
            state_d    = ST_ADV;
          end else begin
            dx_d      = shreg_q[31];
            shreg_d   = {shreg_q[30:0], 1'b0};
            fsx_d     = (bit_cnt_q == 6'd0);
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end
      end

      ST_ADV: begin
        adv_cnt_d = adv_cnt_q + 3'd1;
        if (adv_cnt_q == ADV_LAST) begin
          if ((word_cnt_q == WORDS_TARGET) || !tx_enable) begin
            state_d = ST_IDLE;
          end else begin
            state_d    = ST_FETCH;
            wait_cnt_d = '0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and datapath registers; reset aborts any word in flight
  always_ff @(posedge clk_50m or posedge cfg_rst) begin
    if (cfg_rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      shreg_q    <= 32'd0;
      bit_cnt_q  <= 6'd0;
      adv_cnt_q  <= 3'd0;
      word_cnt_q <= 16'd0;
      dx_q       <= 1'b0;
      fsx_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      adv_cnt_q  <= adv_cnt_d;
      word_cnt_q <= word_cnt_d;
      dx_q       <= dx_d;
      fsx_q      <= fsx_d;
    end
  end

  // Advance strobe is high for the first half of ADV; overrun flags a dropped request
  assign data_updated = (state_q == ST_ADV) && !adv_cnt_q[2];
  assign overrun      = read_quest && !((state_q == ST_IDLE) && tx_enable) && !cfg_rst;
  assign busy         = (state_q != ST_IDLE);
  assign mcbsp_clkx   = clkx_q;
  assign mcbsp_fsx    = fsx_q;
  assign mcbsp_dx     = dx_q;
  assign word_cnt     = word_cnt_q;

endmodule
